// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_mc_ctrl
//  Purpose  : Multicycle MIPS control FSM. Sequences the shared datapath
//             (single memory port, one ALU, PC, IR, register file), decodes
//             op/funct and stalls on the memory ready handshake.
//  Options  : MIPS_CTRL_PERF_EN adds retired_cnt / stall_cnt counters.
//  Revision : 1.0  initial release
// ============================================================================
module mips_mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_ctrl,
    output logic [1:0]      pc_src,
    output logic            instr_done,
    output logic            illegal,
    output logic [ST_W-1:0] state
`ifdef MIPS_CTRL_PERF_EN
    ,
    output logic [31:0]     retired_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    typedef enum logic [ST_W-1:0] {
        S_RESET  = ST_W'(0),
        S_FETCH  = ST_W'(1),
        S_DECODE = ST_W'(2),
        S_MEMADR = ST_W'(3),
        S_MEMRD  = ST_W'(4),
        S_MEMWB  = ST_W'(5),
        S_MEMWR  = ST_W'(6),
        S_EXEC   = ST_W'(7),
        S_ALUWB  = ST_W'(8),
        S_BRANCH = ST_W'(9),
        S_ADDIEX = ST_W'(10),
        S_ADDIWB = ST_W'(11),
        S_JUMP   = ST_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q;
    state_t state_d;
    logic   funct_ok;
    logic   stall;

    // Supported R-type functions
    always_comb begin
        funct_ok = (funct == 6'b100000) || (funct == 6'b100010) ||
                   (funct == 6'b100100) || (funct == 6'b100101) ||
                   (funct == 6'b101010);
    end

    // Output decode (Moore on state, plus zero/mem_ready where handshaked) and next state
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_AND;
        pc_src     = 2'b00;
        instr_done = 1'b0;
        illegal    = 1'b0;
        stall      = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                stall     = ~mem_ready;
                state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here
                alu_src_b = 2'b11;
                alu_ctrl  = ALU_ADD;
                case (op)
                    OP_RTYPE: begin
                        state_d = funct_ok ? S_EXEC : S_FETCH;
                        illegal = ~funct_ok;
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                stall    = ~mem_ready;
                state_d  = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                stall      = ~mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                case (funct)
                    6'b100010: alu_ctrl = ALU_SUB;
                    6'b100100: alu_ctrl = ALU_AND;
                    6'b100101: alu_ctrl = ALU_OR;
                    6'b101010: alu_ctrl = ALU_SLT;
                    default:   alu_ctrl = ALU_ADD;
                endcase
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_src     = 2'b01;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_ctrl  = ALU_ADD;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State register, cleared asynchronously so outputs drop as soon as rst_n falls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    assign state = state_q;

`ifdef MIPS_CTRL_PERF_EN
    // Retired-instruction and memory-stall counters, wrapping at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'd0;
            stall_cnt   <= 32'd0;
        end else begin
            if (instr_done) retired_cnt <= retired_cnt + 32'd1;
            if (stall)      stall_cnt   <= stall_cnt + 32'd1;
        end
    end
`else
    logic unused_stall;
    assign unused_stall = stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_mc_ctrl
//  Purpose  : Directed self-checking bench for mips_mc_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_mc_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic [1:0] pc_src;
    logic       instr_done, illegal;
    logic [3:0] state;
`ifdef MIPS_CTRL_PERF_EN
    logic [31:0] retired_cnt, stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal),
        .state(state)
`ifdef MIPS_CTRL_PERF_EN
        , .retired_cnt(retired_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are stable well before the next edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] lw_st [10] = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4, 4'd5};
    logic       lw_mr [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int         done_cnt;
    int         wr_cnt;
    int         both_cnt;

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
        // ---------------- reset state ----------------
        cyc();
        chk("reset_state", state, 4'd0);
        chk("reset_memread", mem_read, 1'b0);
        chk("reset_pcwrite", pc_write, 1'b0);
        cyc();
        rst_n = 1'b1;
        #1;
        chk("release_still_reset", state, 4'd0);
        cyc();
        chk("fetch_state", state, 4'd1);
        chk("fetch_memread", mem_read, 1'b1);
        chk("fetch_srcb", alu_src_b, 2'b01);
        chk("fetch_aluctrl", alu_ctrl, 3'b010);
        chk("fetch_irwrite_rdy", ir_write, 1'b1);
        chk("fetch_pcwrite_rdy", pc_write, 1'b1);

        // ---------------- lw with stalls ----------------
        op = 6'b100011;
        mem_ready = 1'b0;
        #1;
        chk("fetch_pcwrite_stall", pc_write, 1'b0);
        chk("fetch_irwrite_stall", ir_write, 1'b0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = lw_mr[i];
            #1;
            chk($sformatf("lw_state_%0d", i), state, lw_st[i]);
            chk($sformatf("lw_regwrite_%0d", i), reg_write, (lw_st[i] == 4'd5));
            if (lw_st[i] == 4'd4) chk($sformatf("lw_iord_%0d", i), iord, 1'b1);
            if (instr_done) done_cnt++;
            cyc();
        end
        chk("lw_done_once", done_cnt, 1);
        chk("lw_back_fetch", state, 4'd1);

        // ---------------- R-type slt ----------------
        op = 6'b000000; funct = 6'b101010; mem_ready = 1'b1;
        cyc();
        chk("slt_decode", state, 4'd2);
        chk("decode_srcb", alu_src_b, 2'b11);
        chk("slt_not_illegal", illegal, 1'b0);
        cyc();
        chk("slt_exec", state, 4'd7);
        chk("slt_aluctrl", alu_ctrl, 3'b111);
        chk("exec_srca", alu_src_a, 1'b1);
        cyc();
        chk("slt_aluwb", state, 4'd8);
        chk("aluwb_regdst", reg_dst, 1'b1);
        chk("aluwb_regwrite", reg_write, 1'b1);
        chk("aluwb_done", instr_done, 1'b1);
        cyc();
        chk("slt_fetch", state, 4'd1);

        // ---------------- illegal funct ----------------
        funct = 6'b000111;
        cyc();
        chk("ill_decode", state, 4'd2);
        chk("ill_pulse", illegal, 1'b1);
        chk("ill_no_regwrite", reg_write, 1'b0);
        cyc();
        chk("ill_fetch", state, 4'd1);
        chk("ill_pulse_gone", illegal, 1'b0);

        // ---------------- beq ----------------
        op = 6'b000100; zero = 1'b1;
        cyc(); cyc();
        chk("beq_state", state, 4'd9);
        chk("beq_pcwrite_z1", pc_write, 1'b1);
        chk("beq_pcsrc", pc_src, 2'b01);
        chk("beq_aluctrl", alu_ctrl, 3'b110);
        zero = 1'b0;
        #1;
        chk("beq_pcwrite_z0", pc_write, 1'b0);
        cyc();
        chk("beq_fetch", state, 4'd1);

        // ---------------- sw ----------------
        op = 6'b101011;
        wr_cnt = 0; both_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (mem_write) begin
                wr_cnt++;
                chk("sw_iord", iord, 1'b1);
                chk("sw_done", instr_done, 1'b1);
            end
            if (mem_write && mem_read) both_cnt++;
            cyc();
        end
        chk("sw_write_cycles", wr_cnt, 1);
        chk("sw_rd_wr_overlap", both_cnt, 0);
        chk("sw_next_decode", state, 4'd2);

        // ---------------- j (entered from DECODE) ----------------
        op = 6'b000010;
        cyc();
        chk("j_state", state, 4'd12);
        chk("j_pcwrite", pc_write, 1'b1);
        chk("j_pcsrc", pc_src, 2'b10);
        cyc();
        chk("j_fetch", state, 4'd1);

        // ---------------- addi ----------------
        op = 6'b001000;
        cyc(); cyc();
        chk("addi_ex", state, 4'd10);
        chk("addi_srcb", alu_src_b, 2'b10);
        cyc();
        chk("addi_wb", state, 4'd11);
        chk("addi_regwrite", reg_write, 1'b1);
        chk("addi_regdst", reg_dst, 1'b0);
        cyc();

        // ---------------- async reset mid-EXEC ----------------
        op = 6'b000000; funct = 6'b100000;
        cyc(); cyc();
        chk("rst_pre_exec", state, 4'd7);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", state, 4'd0);
        chk("async_rst_srca", alu_src_a, 1'b0);
        chk("async_rst_aluctrl", alu_ctrl, 3'b000);
        cyc();
        chk("rst_hold", state, 4'd0);
        rst_n = 1'b1;
        cyc();
        chk("rst_release_fetch", state, 4'd1);

`ifdef MIPS_CTRL_PERF_EN
        // ---------------- perf counters: 3 jumps, 4 stall cycles ----------------
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        chk("perf_clear_ret", retired_cnt, 32'd0);
        op = 6'b000010; mem_ready = 1'b0;
        cyc();           // RESET -> FETCH
        cyc(); cyc(); cyc(); cyc();
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        chk("perf_retired", retired_cnt, 32'd3);
        chk("perf_stall", stall_cnt, 32'd4);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #20000;
        failures++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
